umi_port_arbiter: RTL and testbench
===================================

// Module: umi_port_arbiter
// PURPOSE
//  Shares one UMI outbound/inbound port pair between NREQ requesters, e.g. several AXI-to-UMI bridges.
//  Outbound: round-robin arbitration with a registered output stage; one packet in flight, bubble-tolerant.
//  Inbound: read responses go back to the requester that issued the read, using an in-order ID FIFO.
//  Sits between the requester bridges and the single UMI endpoint of the device under test.
// PARAMETERS
//  NREQ   4   number of requesters (>=2)
//  DEPTH  8   outstanding-read ID FIFO entries (power of 2)
//  IDW    $clog2(NREQ)  requester ID width (derived, do not override)
// PORTS
//  clk              in   1          clock
//  rst              in   1          synchronous active-high reset
//  req_out_packet   in   256*NREQ   requester i packet at [256*i +: 256]
//  req_out_valid    in   NREQ       requester i packet valid
//  req_out_ready    out  NREQ       requester i packet accepted (combinational)
//  req_in_packet    out  256        inbound packet, broadcast to all requesters
//  req_in_valid     out  NREQ       inbound packet valid for requester i
//  req_in_ready     in   NREQ       requester i accepts inbound packet
//  umi_out_packet   out  256        shared outbound packet (registered)
//  umi_out_valid    out  1          shared outbound valid (registered)
//  umi_out_ready    in   1          shared outbound ready
//  umi_in_packet    in   256        shared inbound packet
//  umi_in_valid     in   1          shared inbound valid
//  umi_in_ready     out  1          shared inbound ready (combinational)
//  err_unexpected   out  1          sticky: response received with ID FIFO empty
//  rd_outstanding   out  IDW+... $clog2(DEPTH+1)  current ID FIFO occupancy
// BEHAVIOUR
//  - Reset values: umi_out_valid=0, umi_out_packet=0, err_unexpected=0, FIFO empty, rr pointer=0, state IDLE.
//  - Reset mid-operation drops any held packet and flushes all IDs. No handshake completes in a reset cycle.
//  - Opcode is packet[7:0]. Read request = 8'h08; read response = 8'h01. Other opcodes are writes (no response tracked).
//  - States: IDLE, SEND.
//    - IDLE: grant = first i with req_out_valid[i], searching from ptr upward and wrapping at NREQ-1.
//    - A read request is not eligible while the FIFO is full, even if a pop occurs in the same cycle. Skip it; others stay eligible.
//    - req_out_ready[grant]=1, only in IDLE; all other bits are 0.
//    - On that handshake: capture packet into umi_out_packet, set umi_out_valid. If it is a read, push grant ID.
//    - Then set ptr=(grant+1) mod NREQ and go to SEND. Latency from valid to umi_out_valid is 1 cycle.
//    - SEND: hold packet and valid stable. On umi_out_ready, clear umi_out_valid and return to IDLE.
//    - Minimum 2 cycles per packet (one bubble).
//  - Inbound routing, FIFO non-empty:
//    - req_in_valid[head]=umi_in_valid, other bits 0; umi_in_ready=req_in_ready[head].
//    - Pop on umi_in_valid&&umi_in_ready. Responses are in order.
//  - Inbound, FIFO empty: req_in_valid=0, umi_in_ready=1. The packet is dropped and err_unexpected sets.
//    err_unexpected is cleared only by rst.
//  - req_in_packet=umi_in_packet, always passed through.
//  - Push and pop in the same cycle are both allowed and leave occupancy unchanged.
//  - rd_outstanding tracks occupancy and never exceeds DEPTH. Pointers wrap modulo DEPTH.
//  - Inbound opcode is not checked here; requesters validate it.
// TESTING
//  1. Single write from req 1 (opcode 8'h01): out_valid rises next cycle with the identical packet.
//     Hold 3 cycles with umi_out_ready=0, then accept. rd_outstanding stays 0.
//  2. All 4 requesters valid continuously with writes: grant order 0,1,2,3,0,1. Each packet appears once, no starvation.
//  3. Reads from req 2 then req 0: responses A,B are routed to req 2 then req 0.
//     With req_in_ready[2]=0 for 5 cycles, umi_in_ready stays 0 and nothing pops.
//  4. DEPTH=8 reads outstanding: rd_outstanding=8, a further read is held off, and a write from another requester is still granted.
//     After one response the held read is granted next IDLE.
//  5. Response with the FIFO empty: umi_in_ready=1, no req_in_valid bit set, err_unexpected=1 and stays set.
//  6. Assert rst while in SEND with 3 reads outstanding: next cycle umi_out_valid=0, rd_outstanding=0, ptr=0.

Source files
------------

// File: rtl/umi_port_arbiter.sv
// Round-robin arbiter sharing one UMI port pair between NREQ requesters.
// Outbound packets are registered; read responses are routed back in order through an ID FIFO.
module umi_port_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [256*NREQ-1:0]   req_out_packet,
    input  logic [NREQ-1:0]       req_out_valid,
    output logic [NREQ-1:0]       req_out_ready,
    output logic [255:0]          req_in_packet,
    output logic [NREQ-1:0]       req_in_valid,
    input  logic [NREQ-1:0]       req_in_ready,
    output logic [255:0]          umi_out_packet,
    output logic                  umi_out_valid,
    input  logic                  umi_out_ready,
    input  logic [255:0]          umi_in_packet,
    input  logic                  umi_in_valid,
    output logic                  umi_in_ready,
    output logic                  err_unexpected,
    output logic [CW-1:0]         rd_outstanding
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] OP_RD_REQ = 8'h08;

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_next;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant;
    logic           found;
    logic [NREQ-1:0] eligible;
    logic [255:0]   sel_packet;
    logic           out_fire;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [IDW-1:0] ids [DEPTH];
    logic [IDW-1:0] head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = ids[rd_ptr];

    // Reads are held off while the ID FIFO is full, judged on current occupancy only.
    for (genvar i = 0; i < NREQ; i++) begin : g_elig
        assign eligible[i] = req_out_valid[i] &&
                             !(full && (req_out_packet[256*i +: 8] == OP_RD_REQ));
    end

    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {{(32-IDW){1'b0}}, ptr} + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && eligible[IDW'(idx)]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_packet = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant) sel_packet = req_out_packet[256*i +: 256];
        end
    end

    assign out_fire = !rst && (state == IDLE) && found;
    assign push     = out_fire && (sel_packet[7:0] == OP_RD_REQ);

    always_comb begin
        state_next    = state;
        req_out_ready = '0;
        case (state)
            IDLE: begin
                if (out_fire) begin
                    req_out_ready[grant] = 1'b1;
                    state_next           = SEND;
                end
            end
            SEND: begin
                if (umi_out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign umi_out_valid = (state == SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            umi_out_packet <= '0;
            ptr            <= '0;
        end else if (out_fire) begin
            umi_out_packet <= sel_packet;
            ptr            <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
        end
    end

    always_comb begin
        req_in_valid = '0;
        umi_in_ready = 1'b0;
        if (!rst) begin
            if (empty) begin
                umi_in_ready = 1'b1;
            end else begin
                req_in_valid[head] = umi_in_valid;
                umi_in_ready       = req_in_ready[head];
            end
        end
    end

    assign req_in_packet = umi_in_packet;
    assign pop           = umi_in_valid && umi_in_ready && !empty;

    always_ff @(posedge clk) begin
        if (push) ids[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (umi_in_valid && empty) err_unexpected <= 1'b1;
        end
    end

    assign rd_outstanding = count;

endmodule

// File: tb/tb_umi_port_arbiter.sv
// Randomized bench for umi_port_arbiter, checked every cycle against a queue-based
// transaction model of the arbitration and response-routing rules.
module tb_umi_port_arbiter;
    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int PW    = 256;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [PW*NREQ-1:0]   req_out_packet = '0;
    logic [NREQ-1:0]      req_out_valid = '0;
    logic [NREQ-1:0]      req_out_ready;
    logic [PW-1:0]        req_in_packet;
    logic [NREQ-1:0]      req_in_valid;
    logic [NREQ-1:0]      req_in_ready = '0;
    logic [PW-1:0]        umi_out_packet;
    logic                 umi_out_valid;
    logic                 umi_out_ready = 1'b0;
    logic [PW-1:0]        umi_in_packet = '0;
    logic                 umi_in_valid = 1'b0;
    logic                 umi_in_ready;
    logic                 err_unexpected;
    logic [3:0]           rd_outstanding;

    umi_port_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_out_packet (req_out_packet),
        .req_out_valid  (req_out_valid),
        .req_out_ready  (req_out_ready),
        .req_in_packet  (req_in_packet),
        .req_in_valid   (req_in_valid),
        .req_in_ready   (req_in_ready),
        .umi_out_packet (umi_out_packet),
        .umi_out_valid  (umi_out_valid),
        .umi_out_ready  (umi_out_ready),
        .umi_in_packet  (umi_in_packet),
        .umi_in_valid   (umi_in_valid),
        .umi_in_ready   (umi_in_ready),
        .err_unexpected (err_unexpected),
        .rd_outstanding (rd_outstanding)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model: one held packet, a queue of requester IDs awaiting responses, a rotating priority.
    bit          m_busy = 1'b0;
    logic [PW-1:0] m_held = '0;
    int          m_q[$];
    int          m_ptr = 0;
    bit          m_err = 1'b0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt(input bit rd);
        logic [PW-1:0] p;
        int unsigned   op;
        for (int w = 0; w < PW/32; w++) p[32*w +: 32] = $urandom;
        op = $urandom_range(0, 255);
        if (op == 8) op = 1;
        p[7:0] = rd ? 8'h08 : op[7:0];
        return p;
    endfunction

    task automatic step(input int pv, input int pr, input int pi, input int po,
                        input int pa, input int prst);
        int            grant;
        int            head;
        int            idx;
        logic [NREQ-1:0] exp_ord;
        logic [NREQ-1:0] exp_ivalid;
        logic          exp_irdy;
        logic [PW-1:0] gpkt;

        @(negedge clk);
        rst = ($urandom_range(0, 99) < prst);
        for (int i = 0; i < NREQ; i++) begin
            req_out_valid[i]            = ($urandom_range(0, 99) < pv);
            req_out_packet[PW*i +: PW]  = rand_pkt($urandom_range(0, 99) < pr);
            req_in_ready[i]             = ($urandom_range(0, 99) < pa);
        end
        umi_out_ready = ($urandom_range(0, 99) < po);
        umi_in_valid  = ($urandom_range(0, 99) < pi);
        umi_in_packet = rand_pkt(1'b0);
        #1;

        grant   = -1;
        exp_ord = '0;
        if (!rst && !m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                idx  = (m_ptr + k) % NREQ;
                gpkt = req_out_packet[PW*idx +: PW];
                if (grant < 0 && req_out_valid[idx] &&
                    !(gpkt[7:0] == 8'h08 && m_q.size() >= DEPTH))
                    grant = idx;
            end
        end
        if (grant >= 0) exp_ord[grant] = 1'b1;

        exp_ivalid = '0;
        exp_irdy   = 1'b0;
        head       = -1;
        if (!rst) begin
            if (m_q.size() == 0) begin
                exp_irdy = 1'b1;
            end else begin
                head             = m_q[0];
                exp_ivalid[head] = umi_in_valid;
                exp_irdy         = req_in_ready[head];
            end
        end

        check("out_valid",  umi_out_valid,  m_busy);
        check("out_packet", umi_out_packet, m_held);
        check("rd_outstanding", rd_outstanding, m_q.size());
        check("err_unexpected", err_unexpected, m_err);
        check("req_out_ready",  req_out_ready,  exp_ord);
        check("req_in_valid",   req_in_valid,   exp_ivalid);
        check("umi_in_ready",   umi_in_ready,   exp_irdy);
        check("req_in_packet",  req_in_packet,  umi_in_packet);

        if (rst) begin
            m_busy = 1'b0;
            m_held = '0;
            m_q.delete();
            m_ptr  = 0;
            m_err  = 1'b0;
        end else begin
            if (umi_in_valid) begin
                if (head < 0)              m_err = 1'b1;
                else if (req_in_ready[head]) void'(m_q.pop_front());
            end
            if (m_busy) begin
                if (umi_out_ready) m_busy = 1'b0;
            end else if (grant >= 0) begin
                gpkt   = req_out_packet[PW*grant +: PW];
                m_held = gpkt;
                m_busy = 1'b1;
                if (gpkt[7:0] == 8'h08) m_q.push_back(grant);
                m_ptr  = (grant + 1) % NREQ;
            end
        end
    endtask

    initial begin
        repeat (3)   step(50, 50,  0,  50, 50, 100);
        repeat (400) step(30, 50, 20,  70, 70,   0);
        repeat (400) step(80, 90,  5,  90, 50,   0);
        repeat (400) step(60, 50, 60,  40, 80,   1);
        repeat (300) step(100, 0,  0,  60, 50,   0);
        repeat (300) step(50, 70, 30,  60, 30,   2);
        repeat (300) step(90, 95, 10, 100, 90,   1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
